// File: rtl/main_mem_arbiter_pkg.sv
// Shared types for the main-memory arbiter.
// Optional perf counters: MAIN_MEM_ARB_PERF_EN.
package main_mem_arb_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } arb_state_t;

  typedef enum logic {
    OWN_I,
    OWN_D
  } owner_t;

endpackage

// File: rtl/main_mem_arbiter_if.sv
// Requester and memory-port bundle for the arbiter.
// slave = arbiter side, master = requesters/memory side.
interface main_mem_arbiter_if #(
  parameter int DATA_WIDTH = 32
);

  logic                  i_req;
  logic [DATA_WIDTH-1:0] i_addr;
  logic                  i_ack;
  logic [DATA_WIDTH-1:0] i_rdata;
  logic                  d_req;
  logic                  d_we;
  logic [DATA_WIDTH-1:0] d_addr;
  logic [DATA_WIDTH-1:0] d_wdata;
  logic                  d_ack;
  logic [DATA_WIDTH-1:0] d_rdata;
  logic [DATA_WIDTH-1:0] mem_addr;
  logic                  mem_re;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem_wd;
  logic [DATA_WIDTH-1:0] mem_rd;
  logic                  stall_f;
  logic                  stall_m;

  modport slave (
    input  i_req, i_addr,
    input  d_req, d_we, d_addr, d_wdata,
    input  mem_rd,
    output i_ack, i_rdata,
    output d_ack, d_rdata,
    output mem_addr, mem_re, mem_we, mem_wd,
    output stall_f, stall_m
  );

  modport master (
    output i_req, i_addr,
    output d_req, d_we, d_addr, d_wdata,
    output mem_rd,
    input  i_ack, i_rdata,
    input  d_ack, d_rdata,
    input  mem_addr, mem_re, mem_we, mem_wd,
    input  stall_f, stall_m
  );

endinterface

// File: rtl/main_mem_arbiter_picker.sv
// Round-robin choice between I and D refill requests.
// On a tie the side not granted last time wins.
module arb_rr_picker
  import main_mem_arb_pkg::*;
(
  input  logic   i_req,
  input  logic   d_req,
  input  owner_t last_grant,
  output logic   grant_valid,
  output owner_t grant_owner
);

  // Pick the owner; ties alternate on last_grant.
  always_comb begin
    grant_valid = i_req | d_req;
    grant_owner = OWN_I;
    unique case (1'b1)
      (i_req && d_req):
        grant_owner = (last_grant == OWN_I) ? OWN_D : OWN_I;
      (d_req && !i_req):
        grant_owner = OWN_D;
      default:
        grant_owner = OWN_I;
    endcase
  end

endmodule

// File: rtl/main_mem_arbiter.sv
// Shares one main-memory port between I and D refill.
// Optional perf counters: MAIN_MEM_ARB_PERF_EN.
module main_mem_arbiter
  import main_mem_arb_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_LATENCY = 4
) (
  input logic                clk,
  input logic                reset,
`ifdef MAIN_MEM_ARB_PERF_EN
  output logic [31:0]        perf_conflicts,
  output logic [31:0]        perf_i_grants,
  output logic [31:0]        perf_d_grants,
`endif
  main_mem_arbiter_if.slave  bus
);

  arb_state_t            state;
  owner_t                owner;
  owner_t                last_grant;
  owner_t                grant_owner;
  logic                  grant_valid;
  logic [CNT_W-1:0]      cnt;
  logic [DATA_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] i_rdata_q;
  logic [DATA_WIDTH-1:0] d_rdata_q;
  logic                  we_q;
  logic                  i_ack_w;
  logic                  d_ack_w;
  logic                  grant;

  arb_rr_picker u_picker (
    .i_req       (bus.i_req),
    .d_req       (bus.d_req),
    .last_grant  (last_grant),
    .grant_valid (grant_valid),
    .grant_owner (grant_owner)
  );

  assign grant = (state == IDLE) && grant_valid;

  // Issue / fixed-latency wait / response sequencer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      owner      <= OWN_I;
      last_grant <= OWN_I;
      cnt        <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      i_rdata_q  <= '0;
      d_rdata_q  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (grant_valid) begin
            owner      <= grant_owner;
            last_grant <= grant_owner;
            if (grant_owner == OWN_D) begin
              addr_q  <= bus.d_addr;
              we_q    <= bus.d_we;
              wdata_q <= bus.d_wdata;
            end else begin
              addr_q  <= bus.i_addr;
              we_q    <= 1'b0;
              wdata_q <= '0;
            end
            state <= ISSUE;
          end
        end
        ISSUE: begin
          cnt   <= CNT_W'(MEM_LATENCY - 1);
          state <= WAIT;
        end
        WAIT: begin
          if (cnt == '0) begin
            if (!we_q) begin
              if (owner == OWN_D) d_rdata_q <= bus.mem_rd;
              else                i_rdata_q <= bus.mem_rd;
            end
            state <= RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign i_ack_w = (state == RESP) && (owner == OWN_I);
  assign d_ack_w = (state == RESP) && (owner == OWN_D);

  assign bus.i_ack    = i_ack_w;
  assign bus.d_ack    = d_ack_w;
  assign bus.i_rdata  = i_rdata_q;
  assign bus.d_rdata  = d_rdata_q;
  assign bus.mem_re   = (state == ISSUE) && !we_q;
  assign bus.mem_we   = (state == ISSUE) && we_q;
  assign bus.mem_addr = {addr_q[DATA_WIDTH-1:2], 2'b00};
  assign bus.mem_wd   = wdata_q;
  assign bus.stall_f  = bus.i_req & ~i_ack_w;
  assign bus.stall_m  = bus.d_req & ~d_ack_w;

`ifdef MAIN_MEM_ARB_PERF_EN
  logic conflict;

  assign conflict = bus.i_req & bus.d_req & ~i_ack_w & ~d_ack_w;

  // Contention and per-requester grant counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_conflicts <= '0;
      perf_i_grants  <= '0;
      perf_d_grants  <= '0;
    end else begin
      if (conflict)
        perf_conflicts <= perf_conflicts + 32'd1;
      if (grant && grant_owner == OWN_I)
        perf_i_grants <= perf_i_grants + 32'd1;
      if (grant && grant_owner == OWN_D)
        perf_d_grants <= perf_d_grants + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_main_mem_arbiter.sv
// Directed bench for main_mem_arbiter.
// Perf checks only when MAIN_MEM_ARB_PERF_EN is defined.
module tb_main_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] rd_val = 32'h0;
  int          n_tests = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  main_mem_arbiter_if #(.DATA_WIDTH(32)) bus ();
  main_mem_arbiter_if #(.DATA_WIDTH(32)) bus1 ();

  assign bus.mem_rd  = rd_val;
  assign bus1.mem_rd = bus1.mem_addr ^ 32'hA5A5_0000;

`ifdef MAIN_MEM_ARB_PERF_EN
  logic [31:0] pc0, pi0, pd0;
  logic [31:0] pc1, pi1, pd1;
`endif

  main_mem_arbiter #(.DATA_WIDTH(32), .MEM_LATENCY(4)) dut (
    .clk            (clk),
    .reset          (rst_n),
`ifdef MAIN_MEM_ARB_PERF_EN
    .perf_conflicts (pc0),
    .perf_i_grants  (pi0),
    .perf_d_grants  (pd0),
`endif
    .bus            (bus)
  );

  main_mem_arbiter #(.DATA_WIDTH(32), .MEM_LATENCY(1)) dut1 (
    .clk            (clk),
    .reset          (rst_n),
`ifdef MAIN_MEM_ARB_PERF_EN
    .perf_conflicts (pc1),
    .perf_i_grants  (pi1),
    .perf_d_grants  (pd1),
`endif
    .bus            (bus1)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [5:0] got;
    bus.i_req = 0; bus.i_addr = 0;
    bus.d_req = 0; bus.d_we = 0;
    bus.d_addr = 0; bus.d_wdata = 0;
    bus1.i_req = 0; bus1.i_addr = 0;
    bus1.d_req = 0; bus1.d_we = 0;
    bus1.d_addr = 0; bus1.d_wdata = 0;
    rst_n = 0;
    #12;
    got = {bus.mem_re, bus.mem_we, bus.i_ack,
           bus.d_ack, bus.stall_f, bus.stall_m};
    n_tests++;
    if (got !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_ctl got %b exp 000000", got);
    end
    n_tests++;
    if ({bus.mem_addr, bus.mem_wd, bus.i_rdata, bus.d_rdata}
        !== 128'h0) begin
      n_fail++;
      $display("FAIL reset_data got %h %h %h %h exp 0",
               bus.mem_addr, bus.mem_wd, bus.i_rdata, bus.d_rdata);
    end
    step();
    rst_n = 1;
  endtask

  task automatic test_single_read();
    logic [5:0] got, exp;
    rd_val = 32'hDEAD_BEEF;
    bus.i_addr = 32'h0000_1006;
    bus.i_req = 1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      got = {bus.mem_re, bus.mem_we, bus.i_ack,
             bus.d_ack, bus.stall_f, bus.stall_m};
      exp = {1'(c == 1), 1'b0, 1'(c == 6),
             1'b0, 1'(c <= 5), 1'b0};
      n_tests++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL single_read_ctl c=%0d got %b exp %b",
                 c, got, exp);
      end
      if (c == 1) begin
        n_tests++;
        if (bus.mem_addr !== 32'h0000_1004) begin
          n_fail++;
          $display("FAIL single_read_addr got %h exp 00001004",
                   bus.mem_addr);
        end
      end
      if (c == 6) begin
        n_tests++;
        if (bus.i_rdata !== 32'hDEAD_BEEF) begin
          n_fail++;
          $display("FAIL single_read_data got %h exp deadbeef",
                   bus.i_rdata);
        end
      end
      step();
      if (c == 6) bus.i_req = 0;
    end
  endtask

  task automatic test_write();
    logic [5:0] got, exp;
    bus.d_addr = 32'h20;
    bus.d_wdata = 32'h55;
    bus.d_we = 1;
    bus.d_req = 1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      got = {bus.mem_re, bus.mem_we, bus.i_ack,
             bus.d_ack, bus.stall_f, bus.stall_m};
      exp = {1'b0, 1'(c == 1), 1'b0,
             1'(c == 6), 1'b0, 1'(c <= 5)};
      n_tests++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL write_ctl c=%0d got %b exp %b", c, got, exp);
      end
      if (c == 1) begin
        n_tests++;
        if ({bus.mem_addr, bus.mem_wd} !== {32'h20, 32'h55}) begin
          n_fail++;
          $display("FAIL write_bus got %h/%h exp 00000020/00000055",
                   bus.mem_addr, bus.mem_wd);
        end
      end
      step();
      if (c == 6) begin
        bus.d_req = 0;
        bus.d_we = 0;
      end
    end
  endtask

  task automatic test_tie();
    logic [5:0] got, exp;
    rst_n = 0;
    #3;
    rst_n = 1;
    step();
    for (int r = 0; r < 2; r++) begin
      bus.i_addr = 32'h100 + 32'(r);
      bus.d_addr = 32'h200;
      bus.d_we = 0;
      bus.i_req = 1;
      bus.d_req = 1;
      for (int c = 0; c < 14; c++) begin
        @(negedge clk);
        if (c == 5) rd_val = 32'hCAFE_0000 + 32'(r);
        if (c == 12) rd_val = 32'hBEEF_0000 + 32'(r);
        got = {bus.mem_re, bus.mem_we, bus.i_ack,
               bus.d_ack, bus.stall_f, bus.stall_m};
        exp = {1'(c == 1 || c == 8), 1'b0, 1'(c == 13),
               1'(c == 6), 1'(c <= 12), 1'(c <= 5)};
        n_tests++;
        if (got !== exp) begin
          n_fail++;
          $display("FAIL tie_ctl r=%0d c=%0d got %b exp %b",
                   r, c, got, exp);
        end
        if (c == 6) begin
          n_tests++;
          if (bus.d_rdata !== 32'hCAFE_0000 + 32'(r)) begin
            n_fail++;
            $display("FAIL tie_d_data r=%0d got %h", r, bus.d_rdata);
          end
        end
        if (c == 13) begin
          n_tests++;
          if (bus.i_rdata !== 32'hBEEF_0000 + 32'(r)) begin
            n_fail++;
            $display("FAIL tie_i_data r=%0d got %h", r, bus.i_rdata);
          end
        end
        step();
        if (c == 6) bus.d_req = 0;
        if (c == 13) bus.i_req = 0;
      end
`ifdef MAIN_MEM_ARB_PERF_EN
      if (r == 0) begin
        n_tests++;
        if ({pd0, pi0, pc0} !== {32'd1, 32'd1, 32'd6}) begin
          n_fail++;
          $display("FAIL tie_perf got d=%0d i=%0d c=%0d exp 1 1 6",
                   pd0, pi0, pc0);
        end
      end
`endif
    end
  endtask

  task automatic test_reset_mid();
    logic [5:0] got, exp;
    rd_val = 32'h1234_5678;
    bus.i_addr = 32'h40;
    bus.i_req = 1;
    step();
    step();
    step();
    #2;
    rst_n = 0;
    bus.i_req = 0;
    #1;
    got = {bus.mem_re, bus.mem_we, bus.i_ack,
           bus.d_ack, bus.stall_f, bus.stall_m};
    n_tests++;
    if (got !== 6'b0) begin
      n_fail++;
      $display("FAIL mid_reset_ctl got %b exp 000000", got);
    end
    n_tests++;
    if ({bus.mem_addr, bus.mem_wd, bus.i_rdata, bus.d_rdata}
        !== 128'h0) begin
      n_fail++;
      $display("FAIL mid_reset_data got %h %h %h %h exp 0",
               bus.mem_addr, bus.mem_wd, bus.i_rdata, bus.d_rdata);
    end
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      n_tests++;
      if (bus.i_ack !== 1'b0) begin
        n_fail++;
        $display("FAIL mid_reset_noack c=%0d got %b exp 0",
                 c, bus.i_ack);
      end
    end
    step();
    rst_n = 1;
    bus.i_req = 1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      got = {bus.mem_re, bus.mem_we, bus.i_ack,
             bus.d_ack, bus.stall_f, bus.stall_m};
      exp = {1'(c == 1), 1'b0, 1'(c == 6),
             1'b0, 1'(c <= 5), 1'b0};
      n_tests++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL reissue_ctl c=%0d got %b exp %b", c, got, exp);
      end
      if (c == 6) begin
        n_tests++;
        if (bus.i_rdata !== 32'h1234_5678) begin
          n_fail++;
          $display("FAIL reissue_data got %h exp 12345678",
                   bus.i_rdata);
        end
      end
      step();
      if (c == 6) bus.i_req = 0;
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0]  got, exp;
    logic [31:0] a, al;
    a = 32'h300;
    bus1.i_addr = a;
    bus1.i_req = 1;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      got = {bus1.mem_re, bus1.i_ack};
      exp = {1'(c % 4 == 1), 1'(c % 4 == 3)};
      n_tests++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL b2b_ctl c=%0d got %b exp %b", c, got, exp);
      end
      if (c % 4 == 3) begin
        al = a & 32'hFFFF_FFFC;
        n_tests++;
        if (bus1.i_rdata !== (al ^ 32'hA5A5_0000)) begin
          n_fail++;
          $display("FAIL b2b_data c=%0d got %h exp %h",
                   c, bus1.i_rdata, al ^ 32'hA5A5_0000);
        end
      end
      step();
      if (c % 4 == 3) begin
        a = a + 32'h45;
        bus1.i_addr = a;
      end
      if (c == 15) bus1.i_req = 0;
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_write();
    test_tie();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/main_mem_arbiter.md
Name: main_mem_arbiter

Overview:
- Shares the single main-memory port between two requesters: instruction-fetch refill (I) and data-cache refill/write-back (D).
- Sits between the fetch-stage cache, the memwrite-stage cache and the main memory.
- Sequences each access through issue, fixed-latency wait and response.
- Produces per-stage stall signals for the hazard unit.

Parameters:
- DATA_WIDTH, 32, data and address width.
- MEM_LATENCY, 4, memory access latency in cycles; legal range 1..15.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset; state is cleared while reset==0.
- i_req  input  1  instruction refill request; held until i_ack.
- i_addr  input  DATA_WIDTH  instruction refill address.
- i_ack  output  1  one-cycle pulse; i_rdata valid in the same cycle.
- i_rdata  output  DATA_WIDTH  refill word for I.
- d_req  input  1  data request; held until d_ack.
- d_we  input  1  1 = write-back, 0 = refill read.
- d_addr  input  DATA_WIDTH  data address.
- d_wdata  input  DATA_WIDTH  write-back word.
- d_ack  output  1  one-cycle pulse; d_rdata valid in the same cycle (reads).
- d_rdata  output  DATA_WIDTH  refill word for D.
- mem_addr  output  DATA_WIDTH  word-aligned memory address.
- mem_re  output  1  memory read enable.
- mem_we  output  1  memory write enable.
- mem_wd  output  DATA_WIDTH  memory write data.
- mem_rd  input  DATA_WIDTH  memory read data.
- stall_f  output  1  fetch stall = i_req & ~i_ack (combinational).
- stall_m  output  1  memory-stage stall = d_req & ~d_ack (combinational).

Behaviour:
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - No request: stay in IDLE.
  - Only one requester active: grant it.
  - Both requesters active: grant the one NOT in last_grant (round-robin).
  - On a grant: latch addr, we (I is always a read) and wdata; latch the granted owner; update last_grant; go to ISSUE.
- ISSUE (1 cycle):
  - mem_re = ~we, mem_we = we.
  - mem_addr = {addr[31:2], 2'b00}; mem_wd = latched wdata.
  - Load cnt = MEM_LATENCY-1; go to WAIT.
- WAIT:
  - mem_addr stays held; mem_re and mem_we are 0.
  - Decrement cnt each cycle.
  - When cnt==0: capture mem_rd into the owner's rdata register (reads only); go to RESP.
  - WAIT lasts exactly MEM_LATENCY cycles.
- RESP (1 cycle): pulse owner's ack = 1; go to IDLE.
- Latency: request first seen in IDLE at cycle 0 gives ack at cycle MEM_LATENCY+2. With both requesters continuously active, the next grant is at cycle MEM_LATENCY+3.
- Requesters may not change addr/we/wdata while req is high and ack has not arrived.
- A req dropped mid-transaction is a protocol violation. The transaction still completes and ack still pulses.
- A new request arriving during ISSUE/WAIT/RESP is queued by being held; it is arbitrated only in IDLE.
- A simultaneous release of one requester and a new request from the other in RESP needs no special case; arbitration happens the next cycle.
- i_rdata/d_rdata hold their last captured value until the next capture for that requester.
- Reset (async, any state, including mid-transaction):
  - State = IDLE, cnt = 0, last_grant = I (first tie goes to D).
  - i_ack = d_ack = 0, mem_re = mem_we = 0.
  - mem_addr = mem_wd = 0, i_rdata = d_rdata = 0.
  - An in-flight access is abandoned with no ack; requesters re-request after reset.

Optional Feature:
- Macro: MAIN_MEM_ARB_PERF_EN.
- When defined, add output ports:
  - perf_conflicts [31:0]: increments each cycle that both requests are high with neither acked.
  - perf_i_grants [31:0] and perf_d_grants [31:0]: increment on each grant.
  - All counters are cleared by reset and wrap at 2^32.
- When not defined, these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package main_mem_arb_pkg:
  - arb_state_t enum {IDLE, ISSUE, WAIT, RESP}.
  - owner_t enum {OWN_I, OWN_D}.
  - CNT_W = 4.
- One sub-module: arb_rr_picker, combinational. Inputs i_req, d_req, last_grant; outputs grant_valid, grant_owner.

Test Plan:
- Single I read, mem_rd=32'hDEADBEEF, MEM_LATENCY=4, i_addr=32'h0000_1006 -> mem_re pulse at cycle 1 with mem_addr=32'h1004; i_ack at cycle 6; i_rdata=32'hDEADBEEF; stall_f high cycles 0-5.
- D write d_addr=32'h20, d_wdata=32'h55 -> mem_we=1 for exactly one cycle with mem_wd=32'h55; mem_re never high; d_ack at cycle 6.
- I and D request together from reset, both held -> D granted first (ack cycle 6); I ack cycle 13; next tie goes to D again.
- Reset driven low during WAIT -> all outputs 0 immediately; no ack; after release, a re-issued request completes normally.
- MEM_LATENCY=1 with back-to-back I reads -> ack every 4 cycles; captured data matches each address.
- With MAIN_MEM_ARB_PERF_EN defined, tie scenario -> perf_d_grants=1, perf_i_grants=1, perf_conflicts=6.
